data_cal_seq: RTL

DATA_CAL_SEQ -- requirements
Module: data_cal_seq

---
 rtl/data_cal_seq_if.sv | 26 ++
 rtl/data_cal_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/data_cal_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : data_cal_seq_if
// Purpose  : Upstream word handshake plus nibble-sum calculator command bus.
// Revision : 1.0 - initial release
// ============================================================================
interface data_cal_seq_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] d;
    logic [1:0]  sel;
    logic        busy;
    logic        done;

    // master = word producer / observer, slave = the sequencer itself
    modport master (
        output in_valid, in_data,
        input  in_ready, d, sel, busy, done
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, d, sel, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/data_cal_seq.sv
`default_nettype none
// ============================================================================
// Module   : data_cal_seq
// Purpose  : Buffers 16-bit words and drives a nibble-sum calculator through
//            LOAD/SUM1/SUM2/SUM3. DATA_CAL_SEQ_FIFO_EN selects a 4-entry FIFO,
//            otherwise a single holding register.
// Revision : 1.0 - initial release
// ============================================================================
module data_cal_seq (
    input  logic          clk,
    input  logic          rst,
    data_cal_seq_if.slave bus
);

`ifdef DATA_CAL_SEQ_FIFO_EN
    localparam int c_depth = 4;
`else
    localparam int c_depth = 1;
`endif
    localparam int c_cw = $clog2(c_depth + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SUM1 = 3'd2,
        S_SUM2 = 3'd3,
        S_SUM3 = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_cw-1:0] r_count;
    logic [c_cw-1:0] w_count_nxt;
    logic            r_ready;
    logic [15:0]     r_d;
    logic [15:0]     w_d_nxt;
    logic [1:0]      r_sel;
    logic [1:0]      w_sel_nxt;
    logic            r_busy;
    logic            r_done;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [15:0]     w_head;

    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && r_ready;
    assign w_pop   = (r_state == S_LOAD) && !w_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

`ifdef DATA_CAL_SEQ_FIFO_EN
    logic [15:0] r_mem [c_depth];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;

    // 2-bit pointers wrap modulo the 4-entry depth on their own
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
    end

    assign w_head = r_mem[r_rd_ptr];
`else
    logic [15:0] r_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= 16'h0000;
        end else if (w_push) begin
            r_hold <= bus.in_data;
        end
    end

    assign w_head = r_hold;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SUM1;
            S_SUM1:  w_state_nxt = S_SUM2;
            S_SUM2:  w_state_nxt = S_SUM3;
            S_SUM3:  w_state_nxt = w_empty ? S_IDLE : S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they are registered yet
    // aligned with the state they belong to.
    always_comb begin
        w_d_nxt   = r_d;
        w_sel_nxt = 2'd0;
        unique case (w_state_nxt)
            S_LOAD:  w_d_nxt   = w_head;
            S_SUM1:  w_sel_nxt = 2'd1;
            S_SUM2:  w_sel_nxt = 2'd2;
            S_SUM3:  w_sel_nxt = 2'd3;
            default: w_sel_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_ready <= 1'b0;
            r_d     <= 16'h0000;
            r_sel   <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != c_cw'(c_depth));
            r_d     <= w_d_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_SUM3);
        end
    end

    assign bus.in_ready = r_ready;
    assign bus.d        = r_d;
    assign bus.sel      = r_sel;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire
